// File: rtl/dram_arbiter_if.sv
// Bundle of master-side and DRAM-side signals for the two-master DRAM arbiter.
// Latency: none (wires only).
// Backpressure: req is held by each master until its ack; the DRAM side never stalls.
//
// Ports (as interface members):
//   m0_* / m1_*  : req, lock, we, addr, wdata in; ack, rdata out (per master)
//   dram_*       : addr, we, wdata out to the DRAM; rdata in (combinational read)
//   busy         : arbiter is in the middle of an access
// Modports: slave = arbiter side, master = requesting/DRAM-model side.
interface dram_arbiter_if #(
  parameter int AW = 32,
  parameter int DW = 32
);
  logic          m0_req;
  logic          m0_lock;
  logic          m0_we;
  logic [AW-1:0] m0_addr;
  logic [DW-1:0] m0_wdata;
  logic          m0_ack;
  logic [DW-1:0] m0_rdata;

  logic          m1_req;
  logic          m1_lock;
  logic          m1_we;
  logic [AW-1:0] m1_addr;
  logic [DW-1:0] m1_wdata;
  logic          m1_ack;
  logic [DW-1:0] m1_rdata;

  logic [AW-1:0] dram_addr;
  logic          dram_we;
  logic [DW-1:0] dram_wdata;
  logic [DW-1:0] dram_rdata;
  logic          busy;

  modport slave (
    input  m0_req, m0_lock, m0_we, m0_addr, m0_wdata,
    input  m1_req, m1_lock, m1_we, m1_addr, m1_wdata,
    input  dram_rdata,
    output m0_ack, m0_rdata, m1_ack, m1_rdata,
    output dram_addr, dram_we, dram_wdata, busy
  );

  modport master (
    output m0_req, m0_lock, m0_we, m0_addr, m0_wdata,
    output m1_req, m1_lock, m1_we, m1_addr, m1_wdata,
    output dram_rdata,
    input  m0_ack, m0_rdata, m1_ack, m1_rdata,
    input  dram_addr, dram_we, dram_wdata, busy
  );
endinterface

// File: rtl/dram_arbiter.sv
// Two-master arbiter/sequencer for the single-port data DRAM (IDLE -> ACC -> RESP).
// Latency: req sampled at edge E, DRAM access in the cycle after E, ack in the second cycle after E.
// Backpressure: req held until ack; inputs sampled only in IDLE; one access per 3 cycles.
//
// Ports: clk, rst_n (async active-low); bus (dram_arbiter_if.slave) carries both
// masters' req/lock/we/addr/wdata/ack/rdata, the DRAM addr/we/wdata/rdata and busy.
// Build option: define DRAM_ARB_RR_EN for round-robin tie breaking; otherwise
// master 0 wins ties. Lock hold and MAX_BURST apply in both builds.
module dram_arbiter #(
  parameter int AW        = 32,
  parameter int DW        = 32,
  parameter int MAX_BURST = 4
) (
  input  logic           clk,
  input  logic           rst_n,
  dram_arbiter_if.slave  bus
);

  typedef enum logic [1:0] {IDLE, ACC, RESP} state_t;

  localparam logic [3:0] MAX_B = 4'(MAX_BURST);

  state_t        state_q, state_d;
  logic [AW-1:0] addr_q, addr_d;
  logic          we_q, we_d;
  logic [DW-1:0] wdata_q, wdata_d;
  logic          gnt_q, gnt_d;
  logic [3:0]    burst_q, burst_d;
  logic          ack0_q, ack0_d, ack1_q, ack1_d;
  logic [DW-1:0] rdata0_q, rdata0_d, rdata1_q, rdata1_d;
  logic          busy_q, busy_d;
`ifdef DRAM_ARB_RR_EN
  logic          last_q, last_d;
`endif

  logic [1:0] req, lock;
  logic       prev_hold, hold, win;

  // Winner selection. burst_q == 0 only straight out of reset, meaning there is
  // no previous winner to hold the grant for.
  always_comb begin
    req       = {bus.m1_req, bus.m0_req};
    lock      = {bus.m1_lock, bus.m0_lock};
    prev_hold = (burst_q != 4'd0) && req[gnt_q] && lock[gnt_q];
    hold      = prev_hold && (burst_q < MAX_B);
    if (hold)                win = gnt_q;
    else if (req == 2'b01)   win = 1'b0;
    else if (req == 2'b10)   win = 1'b1;
    // Locked master used up its burst while the other one waits: yield.
    else if (prev_hold)      win = ~gnt_q;
    else begin
`ifdef DRAM_ARB_RR_EN
      win = ~last_q;
`else
      win = 1'b0;
`endif
    end
  end

  always_comb begin
    state_d  = state_q;
    addr_d   = addr_q;
    we_d     = 1'b0;
    wdata_d  = wdata_q;
    gnt_d    = gnt_q;
    burst_d  = burst_q;
    ack0_d   = 1'b0;
    ack1_d   = 1'b0;
    rdata0_d = rdata0_q;
    rdata1_d = rdata1_q;
    busy_d   = 1'b0;
`ifdef DRAM_ARB_RR_EN
    last_d   = last_q;
`endif
    case (state_q)
      IDLE: begin
        if (|req) begin
          state_d = ACC;
          busy_d  = 1'b1;
          gnt_d   = win;
          addr_d  = win ? bus.m1_addr  : bus.m0_addr;
          wdata_d = win ? bus.m1_wdata : bus.m0_wdata;
          // dram_we is a flop, so it is only ever high during ACC.
          we_d    = win ? bus.m1_we    : bus.m0_we;
          burst_d = hold ? burst_q + 4'd1 : 4'd1;
`ifdef DRAM_ARB_RR_EN
          last_d  = win;
`endif
        end
      end
      ACC: begin
        state_d = RESP;
        busy_d  = 1'b1;
        if (gnt_q) begin
          ack1_d = 1'b1;
          if (!we_q) rdata1_d = bus.dram_rdata;
        end else begin
          ack0_d = 1'b1;
          if (!we_q) rdata0_d = bus.dram_rdata;
        end
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      addr_q   <= '0;
      we_q     <= 1'b0;
      wdata_q  <= '0;
      gnt_q    <= 1'b0;
      burst_q  <= 4'd0;
      ack0_q   <= 1'b0;
      ack1_q   <= 1'b0;
      rdata0_q <= '0;
      rdata1_q <= '0;
      busy_q   <= 1'b0;
`ifdef DRAM_ARB_RR_EN
      last_q   <= 1'b1;
`endif
    end else begin
      state_q  <= state_d;
      addr_q   <= addr_d;
      we_q     <= we_d;
      wdata_q  <= wdata_d;
      gnt_q    <= gnt_d;
      burst_q  <= burst_d;
      ack0_q   <= ack0_d;
      ack1_q   <= ack1_d;
      rdata0_q <= rdata0_d;
      rdata1_q <= rdata1_d;
      busy_q   <= busy_d;
`ifdef DRAM_ARB_RR_EN
      last_q   <= last_d;
`endif
    end
  end

  assign bus.dram_addr  = addr_q;
  assign bus.dram_we    = we_q;
  assign bus.dram_wdata = wdata_q;
  assign bus.m0_ack     = ack0_q;
  assign bus.m1_ack     = ack1_q;
  assign bus.m0_rdata   = rdata0_q;
  assign bus.m1_rdata   = rdata1_q;
  assign bus.busy       = busy_q;

endmodule
